sprite_line_loader: RTL and testbench

Per-scanline sprite fetch sequencer for the VGA sprite engine, generalising the fixed 5-slot loader. Each line start, it walks NUM_SPR sprite slots and issues one or more consecutive reads from the sprite image memory per active slot. Each returned word is steered to its slot's line register with a one-hot load enable, aligned to the memory read latency. It pulses img_load_done when the last word has been delivered.

---
 rtl/sprite_line_loader_if.sv | 30 +++
 rtl/sprite_line_loader.sv | 135 +++++++++++++
 tb/tb_sprite_line_loader.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_line_loader_if.sv
// Bundle between the sprite line loader and the sprite engine / image memory.
// mem_rd qualifies mem_addr; load_en/word_idx mark a returning word and carry no back-pressure.
interface sprite_line_loader_if #(
  parameter int NUM_SPR       = 5,
  parameter int ADDR_W        = 9,
  parameter int WORDS_PER_SPR = 1
);
  localparam int IDX_W = (WORDS_PER_SPR > 1) ? $clog2(WORDS_PER_SPR) : 1;

  logic                      loading_loc;
  logic                      linebegin;
  logic [NUM_SPR-1:0]        spr_active;
  logic [NUM_SPR*ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_rd;
  logic [NUM_SPR-1:0]        load_en;
  logic [IDX_W-1:0]          word_idx;
  logic                      busy;
  logic                      img_load_done;

  modport master (
    output loading_loc, linebegin, spr_active, base_addr,
    input  mem_addr, mem_rd, load_en, word_idx, busy, img_load_done
  );

  modport slave (
    input  loading_loc, linebegin, spr_active, base_addr,
    output mem_addr, mem_rd, load_en, word_idx, busy, img_load_done
  );
endinterface

// File: rtl/sprite_line_loader.sv
// Per-scanline sprite fetch sequencer: walks the sprite slots, issues image reads
// and steers each returning word to its slot with a latency-aligned one-hot enable.
module sprite_line_loader #(
  parameter int NUM_SPR       = 5,
  parameter int ADDR_W        = 9,
  parameter int WORDS_PER_SPR = 1,
  parameter int MEM_LAT       = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  sprite_line_loader_if.slave  bus,
  output logic [1:0]           state_dbg_o
);
  localparam int SLOT_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam int K_W    = (WORDS_PER_SPR > 1) ? $clog2(WORDS_PER_SPR) : 1;
  localparam int CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [NUM_SPR-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0]  base_q [NUM_SPR];
  logic [ADDR_W-1:0]  base_d [NUM_SPR];
  logic               pending_q, pending_d;
  logic               ll_dly_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               rd_q, rd_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [NUM_SPR-1:0] pipe_en_q  [MEM_LAT];
  logic [K_W-1:0]     pipe_idx_q [MEM_LAT];
  logic               trigger;

  assign trigger = (bus.linebegin & ~bus.loading_loc) | (ll_dly_q & ~bus.loading_loc);

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    k_d       = k_q;
    mask_d    = mask_q;
    base_d    = base_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger || pending_q) begin
          state_d   = SCAN;
          mask_d    = bus.spr_active;
          for (int i = 0; i < NUM_SPR; i++) base_d[i] = bus.base_addr[i*ADDR_W +: ADDR_W];
          slot_d    = '0;
          k_d       = '0;
          pending_d = 1'b0;
        end
      end
      SCAN: begin
        if (trigger) pending_d = 1'b1;
        if (mask_q[slot_q] && (k_q != K_W'(WORDS_PER_SPR - 1))) begin
          k_d = k_q + K_W'(1);
        end else begin
          k_d = '0;
          if (slot_q == SLOT_W'(NUM_SPR - 1)) begin
            state_d = DRAIN;
            slot_d  = '0;
            cnt_d   = '0;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (trigger) pending_d = 1'b1;
        if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // The read for the next cycle is decided from next-state values so mem_rd/mem_addr stay registered.
    rd_d   = (state_d == SCAN) && mask_d[slot_d];
    addr_d = base_d[slot_d] + ADDR_W'(k_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      k_q       <= '0;
      mask_q    <= '0;
      for (int i = 0; i < NUM_SPR; i++) base_q[i] <= '0;
      pending_q <= 1'b0;
      ll_dly_q  <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe_en_q[i]  <= '0;
        pipe_idx_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      k_q       <= k_d;
      mask_q    <= mask_d;
      base_q    <= base_d;
      pending_q <= pending_d;
      ll_dly_q  <= bus.loading_loc;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      rd_q      <= rd_d;
      if (rd_d) addr_q <= addr_d;
      // Tag of the read currently on the bus enters the latency pipeline.
      pipe_en_q[0]  <= rd_q ? (NUM_SPR'(1) << slot_q) : '0;
      pipe_idx_q[0] <= rd_q ? k_q : '0;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_en_q[i]  <= pipe_en_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end
    end
  end

  assign bus.mem_addr      = addr_q;
  assign bus.mem_rd        = rd_q;
  assign bus.load_en       = pipe_en_q[MEM_LAT-1];
  assign bus.word_idx      = pipe_idx_q[MEM_LAT-1];
  assign bus.busy          = (state_q != IDLE);
  assign bus.img_load_done = done_q;
  assign state_dbg_o       = state_q;
endmodule

// File: tb/tb_sprite_line_loader.sv
// Bench for sprite_line_loader: directed scenarios plus random traffic, checked
// cycle by cycle against a schedule-based model of the fetch sequence.
module tb_sprite_line_loader;
  localparam int N    = 5;
  localparam int AW   = 9;
  localparam int W    = 4;
  localparam int L    = 2;
  localparam int IW   = (W > 1) ? $clog2(W) : 1;
  localparam int MAXC = 8192;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  sprite_line_loader_if #(.NUM_SPR(N), .ADDR_W(AW), .WORDS_PER_SPR(W)) bus ();

  sprite_line_loader #(.NUM_SPR(N), .ADDR_W(AW), .WORDS_PER_SPR(W), .MEM_LAT(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .state_dbg_o(state_dbg)
  );

  // stimulus state
  logic [N-1:0]  spr_v;
  logic [AW-1:0] base_v [N];
  bit            ll_cur;

  // reference model: per-cycle expectations plus an ordered queue of returning word tags
  bit            exp_rd   [MAXC];
  logic [AW-1:0] exp_addr [MAXC];
  int            exp_en   [MAXC];
  int            exp_idx  [MAXC];
  bit            exp_busy [MAXC];
  bit            exp_done [MAXC];
  logic [31:0]   exp_q[$];
  int            cyc;
  int            free_at;
  bit            pend;
  bit            ll_prev;
  bit            rst_prev;
  bit            armed;
  logic [AW-1:0] cur_addr;
  int            n_checks;
  int            n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [N*AW-1:0] pack_base();
    logic [N*AW-1:0] r;
    for (int i = 0; i < N; i++) r[i*AW +: AW] = base_v[i];
    return r;
  endfunction

  // A sequence started in cycle t: every active slot gets W consecutive reads,
  // every inactive slot costs one idle cycle, then L cycles of drain and a done pulse.
  task automatic schedule(input int t);
    int            c;
    int            sum;
    logic [AW-1:0] a;
    c = t + 1;
    for (int s = 0; s < N; s++) begin
      if (spr_v[s]) begin
        for (int k = 0; k < W; k++) begin
          sum         = int'(base_v[s]) + k;
          a           = AW'(sum % (1 << AW));
          exp_rd[c]   = 1'b1;
          exp_addr[c] = a;
          exp_en[c+L] = 1 << s;
          exp_idx[c+L] = k;
          exp_q.push_back(((1 << s) << 8) | k);
          c++;
        end
      end else begin
        c++;
      end
    end
    for (int i = t + 1; i < c + L; i++) exp_busy[i] = 1'b1;
    exp_done[c+L] = 1'b1;
    free_at = c + L;
  endtask

  task automatic clear_future(input int from);
    for (int i = from; i < MAXC; i++) begin
      exp_rd[i]   = 1'b0;
      exp_addr[i] = '0;
      exp_en[i]   = 0;
      exp_idx[i]  = 0;
      exp_busy[i] = 1'b0;
      exp_done[i] = 1'b0;
    end
  endtask

  // driver: one clock cycle of stimulus, checking, and model update
  task automatic step(input bit lb, input bit ll, input bit rs);
    bit          trig;
    logic [31:0] tag;
    @(posedge clk);
    #1;
    bus.linebegin   = lb;
    bus.loading_loc = ll;
    rst             = rs;
    bus.spr_active  = spr_v;
    bus.base_addr   = pack_base();
    ll_cur          = ll;
    @(negedge clk);
    if (rst_prev) cur_addr = '0;
    if (armed) begin
      check("mem_rd", bus.mem_rd, exp_rd[cyc]);
      if (exp_rd[cyc]) cur_addr = exp_addr[cyc];
      check("mem_addr", bus.mem_addr, cur_addr);
      check("load_en", bus.load_en, exp_en[cyc]);
      if (exp_en[cyc] != 0) check("word_idx", bus.word_idx, exp_idx[cyc]);
      if (bus.load_en != '0) begin
        if (exp_q.size() == 0) begin
          check("sb_extra_load", bus.load_en, 0);
        end else begin
          tag = exp_q.pop_front();
          check("sb_load_tag", (32'(bus.load_en) << 8) | 32'(bus.word_idx), tag);
        end
      end
      check("busy", bus.busy, exp_busy[cyc]);
      check("state_idle", state_dbg == 2'd0, !exp_busy[cyc]);
      check("img_load_done", bus.img_load_done, exp_done[cyc]);
    end
    if (rs) begin
      clear_future(cyc + 1);
      exp_q.delete();
      pend    = 1'b0;
      free_at = cyc + 1;
      ll_prev = 1'b0;
      armed   = 1'b1;
    end else begin
      trig = (lb && !ll) || (ll_prev && !ll);
      if (cyc >= free_at && (trig || pend)) begin
        schedule(cyc);
        pend = 1'b0;
      end else if (trig) begin
        pend = 1'b1;
      end
      ll_prev = ll;
    end
    rst_prev = rs;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, ll_cur, 1'b0);
  endtask

  task automatic set_bases(input int b0, input int b1, input int b2, input int b3, input int b4);
    base_v[0] = AW'(b0);
    base_v[1] = AW'(b1);
    base_v[2] = AW'(b2);
    base_v[3] = AW'(b3);
    base_v[4] = AW'(b4);
  endtask

  task automatic randomize_slots();
    spr_v = N'($urandom_range(0, (1 << N) - 1));
    for (int i = 0; i < N; i++)
      base_v[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(508, 511)) : AW'($urandom_range(0, 511));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    free_at  = 0;
    pend     = 1'b0;
    ll_prev  = 1'b0;
    rst_prev = 1'b0;
    armed    = 1'b0;
    cur_addr = '0;
    ll_cur   = 1'b0;
    clear_future(0);
    spr_v = '0;
    set_bases(0, 0, 0, 0, 0);
    rst             = 1'b1;
    bus.linebegin   = 1'b0;
    bus.loading_loc = 1'b0;
    bus.spr_active  = '0;
    bus.base_addr   = '0;

    repeat (3) step(1'b0, 1'b0, 1'b1);
    idle(3);

    // all slots active
    spr_v = 5'b11111;
    set_bases(10, 20, 30, 40, 50);
    step(1'b1, 1'b0, 1'b0);
    idle(30);

    // sparse mask
    spr_v = 5'b10101;
    step(1'b1, 1'b0, 1'b0);
    idle(30);

    // line start blocked while locations load, falling edge triggers
    spr_v = 5'b11111;
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    idle(5);
    step(1'b0, 1'b0, 1'b0);
    idle(30);

    // address wrap at the top of memory
    spr_v = 5'b00001;
    set_bases(510, 20, 30, 40, 50);
    step(1'b1, 1'b0, 1'b0);
    idle(20);

    // repeated triggers while busy collapse into one pending run; snapshot ignores later changes
    spr_v = 5'b11111;
    set_bases(10, 20, 30, 40, 50);
    step(1'b1, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 1'b0, 1'b0);
    spr_v = 5'b01010;
    set_bases(100, 200, 300, 400, 500);
    idle(1);
    step(1'b1, 1'b0, 1'b0);
    idle(70);

    // reset mid-sequence, then a clean run
    spr_v = 5'b11111;
    set_bases(10, 20, 30, 40, 50);
    step(1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 1'b1);
    idle(4);
    step(1'b1, 1'b0, 1'b0);
    idle(35);

    // empty mask
    spr_v = 5'b00000;
    step(1'b1, 1'b0, 1'b0);
    idle(15);

    // simultaneous line start and falling edge count once
    spr_v = 5'b00110;
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(25);

    // loading_loc rising mid-sequence is harmless; its fall while busy becomes pending
    spr_v = 5'b10011;
    step(1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 1'b0);
    idle(50);

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) randomize_slots();
      step($urandom_range(0, 9) == 0,
           ($urandom_range(0, 11) == 0) ? !ll_cur : ll_cur,
           $urandom_range(0, 299) == 0);
    end
    idle(60);

    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
